demux1to3_buffered: RTL and testbench

- Inverse of the FPU's 3-to-1 operand/result select: takes one recoded-float result stream and routes each word to one of three consumers, selected by a 2-bit code.
- Code mapping: 00→out1, 01→out2, 10→out3. Code 11 is invalid; the word is dropped and counted.
- Each output has a small FIFO, so one stalled consumer does not block words headed to the others.
- Sits between the FPU result stage and the writeback, forwarding and exception consumers.

---
 rtl/demux1to3_buffered.sv | 124 ++++++++++++
 tb/tb_demux1to3_buffered.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to3_buffered.sv
// Routes one recoded-float result stream to three consumers, each behind its own small FIFO.
// Select code 2'b11 drops the word, pulsing drop_pulse and bumping a saturating drop counter.
module demux1to3_buffered #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH:0]   in_data,
    input  logic [1:0]            in_sel,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [DATA_WIDTH:0]   out1_data,
    output logic                  out2_valid,
    input  logic                  out2_ready,
    output logic [DATA_WIDTH:0]   out2_data,
    output logic                  out3_valid,
    input  logic                  out3_ready,
    output logic [DATA_WIDTH:0]   out3_data,
    output logic                  drop_pulse,
    output logic [7:0]            drop_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH:0] mem_q    [3][DEPTH];
    logic [PW-1:0]       rd_ptr_q [3];
    logic [PW-1:0]       wr_ptr_q [3];
    logic [CW-1:0]       cnt_q    [3];

    logic       accept;
    logic [2:0] push;
    logic [2:0] pop;
    logic [2:0] out_valid;
    logic [2:0] out_ready;
    logic       drop_pulse_q;
    logic [7:0] drop_count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Readiness looks only at the target FIFO's count, so a full FIFO stalls
    // even when its consumer is popping this cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (in_sel)
                2'b00:   in_ready = (cnt_q[0] != CNT_FULL);
                2'b01:   in_ready = (cnt_q[1] != CNT_FULL);
                2'b10:   in_ready = (cnt_q[2] != CNT_FULL);
                default: in_ready = 1'b1;
            endcase
        end
    end

    assign accept    = in_valid && in_ready;
    assign out_ready = {out3_ready, out2_ready, out1_ready};

    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < 3; c++) begin
            out_valid[c] = (cnt_q[c] != '0);
            push[c]      = accept && (in_sel == 2'(c));
            pop[c]       = out_valid[c] && out_ready[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[c][i] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (push[c]) begin
                    mem_q[c][wr_ptr_q[c]] <= in_data;
                    wr_ptr_q[c]           <= ptr_inc(wr_ptr_q[c]);
                end
                if (pop[c]) begin
                    rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
                end
                if (push[c] && !pop[c]) begin
                    cnt_q[c] <= cnt_q[c] + CW'(1);
                end else if (pop[c] && !push[c]) begin
                    cnt_q[c] <= cnt_q[c] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_pulse_q <= accept && (in_sel == 2'b11);
            if (accept && (in_sel == 2'b11) && (drop_count_q != 8'hFF)) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign out1_valid = out_valid[0];
    assign out2_valid = out_valid[1];
    assign out3_valid = out_valid[2];
    assign out1_data  = mem_q[0][rd_ptr_q[0]];
    assign out2_data  = mem_q[1][rd_ptr_q[1]];
    assign out3_data  = mem_q[2][rd_ptr_q[2]];
    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux1to3_buffered.sv
// Bench for demux1to3_buffered: queue-based reference model of three FIFOs plus a drop counter,
// driven by directed scenarios and random traffic.
module tb_demux1to3_buffered;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW:0]   in_data = '0;
    logic [1:0]    in_sel = '0;
    logic          out1_valid, out2_valid, out3_valid;
    logic          out1_ready = 1'b0, out2_ready = 1'b0, out3_ready = 1'b0;
    logic [DW:0]   out1_data, out2_data, out3_data;
    logic          drop_pulse;
    logic [7:0]    drop_count;

    int checks = 0;
    int errors = 0;

    logic [DW:0] mq [3][$];
    int          exp_drops = 0;
    bit          exp_pulse = 1'b0;

    logic [2:0]  act_valid;
    logic [DW:0] act_data [3];

    always #5 clk = ~clk;

    assign act_valid = {out3_valid, out2_valid, out1_valid};
    assign act_data[0] = out1_data;
    assign act_data[1] = out2_data;
    assign act_data[2] = out3_data;

    demux1to3_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data),
        .out3_valid (out3_valid),
        .out3_ready (out3_ready),
        .out3_data  (out3_data),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    // One clock of stimulus, entered and left at a falling edge. The model is
    // updated at the rising edge from the spec rules, then outputs are compared.
    task automatic cycle(input bit r, input bit v, input logic [1:0] s,
                         input logic [DW:0] d, input logic [2:0] rdy);
        bit       exp_rdy;
        bit       acc;
        bit [2:0] pops;
        rst = r;
        in_valid = v;
        in_sel = s;
        in_data = d;
        {out3_ready, out2_ready, out1_ready} = rdy;
        #1;
        if (r) exp_rdy = 1'b0;
        else if (s == 2'b11) exp_rdy = 1'b1;
        else exp_rdy = (mq[s].size() < DEPTH);
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready t=%0t sel=%0d got %b want %b", $time, s, in_ready, exp_rdy);
        end
        acc = v && exp_rdy;
        for (int c = 0; c < 3; c++) pops[c] = !r && rdy[c] && (mq[c].size() != 0);
        @(posedge clk);
        if (r) begin
            for (int c = 0; c < 3; c++) mq[c].delete();
            exp_drops = 0;
            exp_pulse = 1'b0;
        end else begin
            for (int c = 0; c < 3; c++) if (pops[c]) void'(mq[c].pop_front());
            exp_pulse = acc && (s == 2'b11);
            if (acc) begin
                if (s == 2'b11) begin
                    if (exp_drops < 255) exp_drops++;
                end else begin
                    mq[s].push_back(d);
                end
            end
        end
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (act_valid[c] !== (mq[c].size() != 0)) begin
                errors++;
                $display("FAIL out%0d_valid t=%0t got %b want %b", c + 1, $time,
                         act_valid[c], mq[c].size() != 0);
            end
            if (mq[c].size() != 0) begin
                checks++;
                if (act_data[c] !== mq[c][0]) begin
                    errors++;
                    $display("FAIL out%0d_data t=%0t got %h want %h", c + 1, $time,
                             act_data[c], mq[c][0]);
                end
            end
        end
        checks++;
        if (drop_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL drop_pulse t=%0t got %b want %b", $time, drop_pulse, exp_pulse);
        end
        checks++;
        if (drop_count !== 8'(exp_drops)) begin
            errors++;
            $display("FAIL drop_count t=%0t got %0d want %0d", $time, drop_count, exp_drops);
        end
    endtask

    function automatic logic [DW:0] rnd_word();
        return {1'($urandom), 32'($urandom)};
    endfunction

    task automatic test_reset();
        cycle(1, 0, 2'b00, '0, 3'b000);
        cycle(1, 0, 2'b00, '0, 3'b000);
        cycle(0, 0, 2'b00, '0, 3'b000);
        checks++;
        if ({out1_data, out2_data, out3_data} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0", out1_data, out2_data, out3_data);
        end
    endtask

    task automatic test_routing();
        cycle(0, 1, 2'b01, 33'h0_3F80_0000, 3'b010);
        cycle(0, 1, 2'b01, 33'h0_4000_0000, 3'b010);
        checks++;
        if (out2_data !== 33'h0_4000_0000 || out1_valid || out3_valid) begin
            errors++;
            $display("FAIL routing_order got d2=%h v1=%b v3=%b want 040000000 0 0",
                     out2_data, out1_valid, out3_valid);
        end
        cycle(0, 0, 2'b01, '0, 3'b010);
        cycle(0, 0, 2'b01, '0, 3'b010);
    endtask

    task automatic test_backpressure();
        cycle(0, 1, 2'b00, 33'h1_0000_0001, 3'b000);
        cycle(0, 1, 2'b00, 33'h1_0000_0002, 3'b000);
        cycle(0, 1, 2'b00, 33'h1_0000_0003, 3'b000);
        cycle(0, 1, 2'b10, 33'h0_C000_0000, 3'b000);
        cycle(0, 1, 2'b00, 33'h1_0000_0003, 3'b001);
        cycle(0, 1, 2'b00, 33'h1_0000_0003, 3'b000);
        for (int i = 0; i < 4; i++) cycle(0, 0, 2'b00, '0, 3'b111);
    endtask

    task automatic test_full_pop();
        cycle(0, 1, 2'b00, 33'h0_1111_1111, 3'b000);
        cycle(0, 1, 2'b00, 33'h0_2222_2222, 3'b000);
        checks++;
        if (out1_data !== 33'h0_1111_1111) begin
            errors++;
            $display("FAIL full_head got %h want 011111111", out1_data);
        end
        cycle(0, 1, 2'b00, 33'h0_3333_3333, 3'b001);
        cycle(0, 1, 2'b00, 33'h0_3333_3333, 3'b000);
        for (int i = 0; i < 3; i++) cycle(0, 0, 2'b00, '0, 3'b001);
    endtask

    task automatic test_drops();
        for (int i = 0; i < 300; i++) cycle(0, 1, 2'b11, rnd_word(), 3'(i));
        checks++;
        if (drop_count !== 8'd255 || drop_pulse !== 1'b1) begin
            errors++;
            $display("FAIL drop_saturate got cnt=%0d pulse=%b want 255 1", drop_count, drop_pulse);
        end
        cycle(0, 0, 2'b11, '0, 3'b000);
    endtask

    task automatic test_mid_reset();
        cycle(0, 1, 2'b10, 33'h0_AAAA_AAAA, 3'b000);
        cycle(0, 1, 2'b10, 33'h0_BBBB_BBBB, 3'b000);
        cycle(1, 1, 2'b10, 33'h0_CCCC_CCCC, 3'b100);
        cycle(0, 1, 2'b10, 33'h1_DDDD_DDDD, 3'b000);
        checks++;
        if (out3_data !== 33'h1_DDDD_DDDD) begin
            errors++;
            $display("FAIL mid_reset_head got %h want 1DDDDDDDD", out3_data);
        end
        cycle(0, 0, 2'b10, '0, 3'b100);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 79) == 0), 1'($urandom), 2'($urandom), rnd_word(),
                  3'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_full_pop();
        test_drops();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
